// File: rtl/input_debounce_pkg.sv
// Shared constants for the input debouncer.
// Defaults and legal ranges of the block parameters.
package input_debounce_pkg;

  localparam int unsigned CH_DEF    = 4;
  localparam int unsigned CH_MIN    = 1;
  localparam int unsigned CH_MAX    = 32;

  localparam int unsigned SYNC_DEF  = 2;
  localparam int unsigned SYNC_MIN  = 2;
  localparam int unsigned SYNC_MAX  = 4;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned CNT_W_MIN = 1;
  localparam int unsigned CNT_W_MAX = 24;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, stability
// counter, filtered level and edge pulses.
module debounce_ch
  import input_debounce_pkg::*;
#(
  parameter int P_SYNC  = SYNC_DEF,
  parameter int P_CNT_W = CNT_W_DEF
) (
  input  logic               sys_clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [P_CNT_W-1:0] thresh_i,
  input  logic               a_i,
  output logic               level_o,
  output logic               rise_o,
  output logic               fall_o
);

  logic [P_SYNC-1:0]  sync_q;
  logic               s;
  logic [P_CNT_W-1:0] lim;
  logic [P_CNT_W-1:0] cnt_q;
  logic [P_CNT_W-1:0] cnt_d;
  logic               level_q;
  logic               level_d;
  logic               rise_q;
  logic               rise_d;
  logic               fall_q;
  logic               fall_d;

  assign s   = sync_q[P_SYNC-1];
  // thresh_i is never zero here, so no underflow
  assign lim = thresh_i - P_CNT_W'(1);

  // synchroniser chain, free-running
  always_ff @(posedge sys_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[P_SYNC-2:0], a_i};
    end
  end

  // count stable cycles, commit level at threshold
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en_i) begin
      if (s == level_q) begin
        cnt_d = '0;
      end else if (cnt_q >= lim) begin
        cnt_d   = '0;
        level_d = s;
        rise_d  = s;
        fall_d  = ~s;
      end else begin
        cnt_d = cnt_q + P_CNT_W'(1);
      end
    end
  end

  // filter state and pulse registers
  always_ff @(posedge sys_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/input_debounce.sv
// Multi-channel input debouncer top: threshold
// clamp and per-channel fan-out.
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int P_CH    = CH_DEF,
  parameter int P_SYNC  = SYNC_DEF,
  parameter int P_CNT_W = CNT_W_DEF
) (
  input  logic               I_sys_clk,
  input  logic               I_rst_n,
  input  logic               I_en,
  input  logic [P_CNT_W-1:0] I_thresh,
  input  logic [P_CH-1:0]    I_a,
  output logic [P_CH-1:0]    O_level,
  output logic [P_CH-1:0]    O_rise,
  output logic [P_CH-1:0]    O_fall
);

  logic [P_CNT_W-1:0] t_eff;

  // a zero threshold behaves as one cycle
  assign t_eff = (I_thresh == '0) ? P_CNT_W'(1)
                                  : I_thresh;

  for (genvar i = 0; i < P_CH; i++) begin : g_ch
    debounce_ch #(
      .P_SYNC  (P_SYNC),
      .P_CNT_W (P_CNT_W)
    ) u_ch (
      .sys_clk_i (I_sys_clk),
      .rst_ni    (I_rst_n),
      .en_i      (I_en),
      .thresh_i  (t_eff),
      .a_i       (I_a[i]),
      .level_o   (O_level[i]),
      .rise_o    (O_rise[i]),
      .fall_o    (O_fall[i])
    );
  end

endmodule
